// File: rtl/matrix_stream_reader_pkg.sv
// Shared types and constants for the matrix store read-side sequencer.
package matrix_stream_reader_pkg;

  localparam int unsigned DIM_MAX = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DIM_W   = 3;
  localparam int unsigned ID_W    = 2;

  // Logical slot IDs: 1 = oldest stored matrix, 2 = newest.
  localparam logic [ID_W-1:0] ID_OLD = 2'd1;
  localparam logic [ID_W-1:0] ID_NEW = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StHdr,
    StFetch,
    StSend,
    StDone
  } rd_state_e;

  // A dimension is legal when it lies in 1..max_dim.
  function automatic logic dim_legal(logic [DIM_W-1:0] d, int unsigned max_dim);
    return (d != '0) && (32'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_stream_reader_if.sv
// Element stream from the reader to the display/UART formatter (valid/ready).
interface matrix_stream_reader_if
  import matrix_stream_reader_pkg::*;
#(
  parameter int unsigned DataW = DATA_W
) ();

  logic [DataW-1:0] data;
  logic             valid;
  logic             ready;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             eol;
  logic             last;
  logic             hdr;

  modport master (
    output data, valid, row, col, eol, last, hdr,
    input  ready
  );

  modport slave (
    input  data, valid, row, col, eol, last, hdr,
    output ready
  );

endinterface

// File: rtl/matrix_stream_reader_rc_counter.sv
// Row/column walk counter for the reader: clear, advance with wrap at n-1,
// and end-of-row / final-element flags for the current position.
module matrix_stream_reader_rc_counter
  import matrix_stream_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [DIM_W-1:0] m_i,
  input  logic [DIM_W-1:0] n_i,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o,
  output logic             eol_o,
  output logic             last_o
);

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;

  assign eol_o  = (col_q == (n_i - DIM_W'(1)));
  assign last_o = eol_o && (row_q == (m_i - DIM_W'(1)));
  assign row_o  = row_q;
  assign col_o  = col_q;

  // Next position: clear wins, otherwise step row-major.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (eol_o) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matrix_stream_reader.sv
// Read-side sequencer for the matrix store: validates a (m,n,id) request, walks the
// stored matrix row-major over the store's combinational read port and emits each
// element on a valid/ready stream.
// Optional: define MATRIX_RD_HEADER_EN to prefix each stream with a header beat
// carrying {5'd0,m,5'd0,n}.
module matrix_stream_reader
  import matrix_stream_reader_pkg::*;
#(
  parameter int unsigned DimMax = DIM_MAX,
  parameter int unsigned DataW  = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      req_m_i,
  input  logic [DIM_W-1:0]      req_n_i,
  input  logic [ID_W-1:0]       req_id_i,
  output logic [DIM_W-1:0]      rd_m_o,
  output logic [DIM_W-1:0]      rd_n_o,
  output logic [ID_W-1:0]       rd_id_o,
  output logic [DIM_W-1:0]      rd_row_o,
  output logic [DIM_W-1:0]      rd_col_o,
  input  logic [DataW-1:0]      rd_data_i,
  input  logic [ID_W-1:0]       rd_count_i,
  matrix_stream_reader_if.master out_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  rd_state_e        state_q;
  logic [DIM_W-1:0] rd_m_q, rd_n_q;
  logic [ID_W-1:0]  rd_id_q;
  logic [DataW-1:0] out_data_q;
  logic             out_valid_q;
  logic [DIM_W-1:0] out_row_q, out_col_q;
  logic             out_eol_q, out_last_q;
  logic             busy_q, done_q, err_q;

  logic             cnt_clr, cnt_adv;
  logic [DIM_W-1:0] cnt_row, cnt_col;
  logic             cnt_eol, cnt_last;
  logic             req_bad;

`ifdef MATRIX_RD_HEADER_EN
  logic             out_hdr_q;
  logic [DataW-1:0] hdr_word;
  assign hdr_word = DataW'({5'd0, rd_m_q, 5'd0, rd_n_q});
`endif

  // Request is rejected on an illegal shape, an unknown ID, or an ID not yet stored.
  assign req_bad = !dim_legal(rd_m_q, DimMax) || !dim_legal(rd_n_q, DimMax) ||
                   (rd_id_q < ID_OLD) || (rd_id_q > ID_NEW) || (rd_id_q > rd_count_i);

  // Counter steps only on an accepted element beat that is not the final one.
  assign cnt_clr = (state_q == StIdle) && start_i;
  assign cnt_adv = (state_q == StSend) && out_if.ready && !cnt_last;

  matrix_stream_reader_rc_counter u_rc_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .m_i    (rd_m_q),
    .n_i    (rd_n_q),
    .row_o  (cnt_row),
    .col_o  (cnt_col),
    .eol_o  (cnt_eol),
    .last_o (cnt_last)
  );

  // Sequencer FSM with all stream/status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_m_q      <= '0;
      rd_n_q      <= '0;
      rd_id_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MATRIX_RD_HEADER_EN
      out_hdr_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rd_m_q  <= req_m_i;
            rd_n_q  <= req_n_i;
            rd_id_q <= req_id_i;
            busy_q  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (req_bad) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
`ifdef MATRIX_RD_HEADER_EN
            out_data_q  <= hdr_word;
            out_valid_q <= 1'b1;
            out_hdr_q   <= 1'b1;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= StHdr;
`else
            state_q     <= StFetch;
`endif
          end
        end
`ifdef MATRIX_RD_HEADER_EN
        StHdr: begin
          if (out_if.ready) begin
            out_valid_q <= 1'b0;
            out_hdr_q   <= 1'b0;
            state_q     <= StFetch;
          end
        end
`endif
        StFetch: begin
          // rd_row/rd_col already point at the counter, so rd_data is this element.
          out_data_q  <= rd_data_i;
          out_row_q   <= cnt_row;
          out_col_q   <= cnt_col;
          out_eol_q   <= cnt_eol;
          out_last_q  <= cnt_last;
          out_valid_q <= 1'b1;
          state_q     <= StSend;
        end
        StSend: begin
          if (out_if.ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_m_o   = rd_m_q;
  assign rd_n_o   = rd_n_q;
  assign rd_id_o  = rd_id_q;
  assign rd_row_o = cnt_row;
  assign rd_col_o = cnt_col;

  assign out_if.data  = out_data_q;
  assign out_if.valid = out_valid_q;
  assign out_if.row   = out_row_q;
  assign out_if.col   = out_col_q;
  assign out_if.eol   = out_eol_q;
  assign out_if.last  = out_last_q;
`ifdef MATRIX_RD_HEADER_EN
  assign out_if.hdr   = out_hdr_q;
`else
  assign out_if.hdr   = 1'b0;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Bench for matrix_stream_reader: a behavioural store plus an expected-beat queue built
// from the request rules, checked on every accepted beat, every stall and every done.
module tb_matrix_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  req_m, req_n;
  logic [1:0]  req_id;
  logic [2:0]  rd_m, rd_n, rd_row, rd_col;
  logic [1:0]  rd_id;
  logic [15:0] rd_data;
  logic [1:0]  rd_count;
  logic        busy, done, err;

  logic [15:0] mem [0:3][0:7][0:7];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [24:0] exp_q[$];
  logic        exp_pending = 1'b0;
  logic        exp_err     = 1'b0;
  logic        prev_hold   = 1'b0;
  logic [24:0] prev_vec;

  matrix_stream_reader_if #(.DataW(16)) s_if ();

  matrix_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .req_m_i    (req_m),
    .req_n_i    (req_n),
    .req_id_i   (req_id),
    .rd_m_o     (rd_m),
    .rd_n_o     (rd_n),
    .rd_id_o    (rd_id),
    .rd_row_o   (rd_row),
    .rd_col_o   (rd_col),
    .rd_data_i  (rd_data),
    .rd_count_i (rd_count),
    .out_if     (s_if),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  // Store read port is combinational.
  assign rd_data = mem[rd_id][rd_row][rd_col];

  wire [24:0] act_vec = {s_if.hdr, s_if.eol, s_if.last, s_if.row, s_if.col, s_if.data};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected beats derived from the request rules and the store contents.
  task automatic push_expect(input int m, input int n, input int id, input int cnt);
    logic bad;
    bad = (m < 1) || (m > 5) || (n < 1) || (n > 5) || (id < 1) || (id > 2) || (id > cnt);
    exp_err     = bad;
    exp_pending = 1'b1;
    if (!bad) begin
`ifdef MATRIX_RD_HEADER_EN
      exp_q.push_back({1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'(m * 256 + n)});
`endif
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++)
          exp_q.push_back({1'b0, (c == n - 1), (r == m - 1) && (c == n - 1),
                           3'(r), 3'(c), mem[id][r][c]});
    end
  endtask

  // Leaves the caller 1ns after the edge that samples start.
  task automatic start_req(input int m, input int n, input int id, input int cnt);
    rd_count = 2'(cnt);
    push_expect(m, n, id, cnt);
    @(posedge clk); #1;
    req_m  = 3'(m);
    req_n  = 3'(n);
    req_id = 2'(id);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy);
    int cyc = 0;
    while (exp_pending && cyc < budget) begin
      @(posedge clk); #1;
      if (rand_rdy) s_if.ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    if (exp_pending) begin
      chk("done_timeout", 32'd0, 32'd1);
      exp_pending = 1'b0;
      exp_q.delete();
    end
    s_if.ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_idle_after_done", busy, 1'b0);
  endtask

  // Scoreboard: accepted beats, held data during stalls, and done/err outcome.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid", s_if.valid, 1'b1);
        chk("stall_hold", act_vec, prev_vec);
      end
      if (s_if.valid) begin
        if (s_if.ready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", act_vec, 32'hFFFF_FFFF);
          else chk("beat", act_vec, exp_q.pop_front());
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_vec  = act_vec;
        end
      end else begin
        prev_hold = 1'b0;
      end
      if (err) chk("err_with_done", done, 1'b1);
      if (done) begin
        if (!exp_pending) begin
          chk("spurious_done", done, 1'b0);
        end else begin
          chk("done_err", err, exp_err);
          chk("beats_left_at_done", exp_q.size(), 0);
          exp_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    req_m      = '0;
    req_n      = '0;
    req_id     = '0;
    rd_count   = '0;
    s_if.ready = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          mem[i][r][c] = {4'(i), 4'(r), 4'(c), 4'hA};

    #2 rst_n = 1'b0;
    #5;
    chk("rst_valid", s_if.valid, 1'b0);
    chk("rst_data", s_if.data, 16'h0);
    chk("rst_busy_done_err", {busy, done, err}, 3'b000);
    chk("rst_rd_bus", {rd_m, rd_n, rd_id, rd_row, rd_col}, 14'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 2x3 from oldest slot, always ready; first beat pinned by hand.
    start_req(2, 3, 1, 2);
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    chk("no_beat_in_check", s_if.valid, 1'b0);
    @(negedge clk);
`ifdef MATRIX_RD_HEADER_EN
    chk("hdr_first_valid", s_if.valid, 1'b1);
    chk("hdr_word_2x3", {s_if.hdr, s_if.data}, 17'h1_0203);
`else
    chk("no_beat_in_fetch", s_if.valid, 1'b0);
    @(negedge clk);
    chk("first_valid_latency", s_if.valid, 1'b1);
    chk("first_beat_2x3", act_vec, {1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h100A});
`endif
    wait_done(60, 1'b0);

    // Newest slot requested with only one matrix stored.
    start_req(3, 3, 2, 1);
    @(negedge clk);
    chk("err_busy_t1", {busy, done}, 2'b10);
    @(negedge clk);
    chk("err_pulse", {busy, done, err}, 3'b111);
    @(negedge clk);
    chk("err_after", {busy, done, err, s_if.valid}, 4'b0000);
    wait_done(20, 1'b0);

    start_req(0, 3, 1, 2);
    wait_done(20, 1'b0);
    start_req(2, 6, 1, 2);
    wait_done(20, 1'b0);
    start_req(2, 2, 3, 3);
    wait_done(20, 1'b0);

    // A second start while busy must not launch another request.
    start_req(2, 3, 2, 2);
    repeat (3) @(posedge clk);
    #1;
    req_m  = 3'd1;
    req_n  = 3'd1;
    req_id = 2'd1;
    start  = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60, 1'b0);

    // 1x1 element.
    mem[1][0][0] = 16'hBEEF;
    start_req(1, 1, 1, 1);
    @(negedge clk);
    chk("1x1_no_beat_t1", s_if.valid, 1'b0);
    @(negedge clk);
`ifdef MATRIX_RD_HEADER_EN
    chk("1x1_hdr", {s_if.valid, s_if.hdr, s_if.data}, 18'h3_0101);
    @(negedge clk);
    @(negedge clk);
`else
    chk("1x1_no_beat_t2", s_if.valid, 1'b0);
    @(negedge clk);
`endif
    chk("1x1_beat", {s_if.valid, s_if.eol, s_if.last, s_if.data}, 19'h7_BEEF);
    wait_done(20, 1'b0);

    // 5x5 under random back-pressure.
    start_req(5, 5, 2, 2);
    wait_done(400, 1'b1);

    // 2x4 (header beat 16'h0204 precedes it when the header is enabled).
    start_req(2, 4, 2, 2);
    wait_done(60, 1'b0);

    // Reset in the middle of a 4x4, then a clean 4x4 from (0,0).
    start_req(4, 4, 1, 2);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_stream", {s_if.valid, s_if.data, s_if.row, s_if.col, s_if.eol, s_if.last},
        25'h0);
    chk("async_rst_status", {busy, done, err, rd_row, rd_col, rd_m}, 12'h0);
    exp_q.delete();
    exp_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_req(4, 4, 1, 2);
    wait_done(80, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
